// File: rtl/mem_wb_stage_if.sv
// Data-memory bus between the MEM stage and the data memory.
//   master (MEM stage): drives dm_req, dm_we, dm_addr, dm_wdata;
//                       samples dm_rdata, dm_ack.
//   slave  (memory)   : the mirror image.
// Handshake: dm_req stays high with dm_we/dm_addr/dm_wdata stable until the
// access ends. The access completes in the cycle where dm_req and dm_ack are
// both high; dm_rdata is valid only in that cycle. dm_ack is ignored while
// dm_req is low. The stage may also drop dm_req after its timeout without an
// ack (abort).
interface mem_wb_stage_if;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ack;

  modport master (
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_rdata, dm_ack
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_rdata, dm_ack
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM stage plus MEM/WB pipeline register.
// Takes the EX/MEM bundle, runs the data-memory access over the dm bus,
// stalls the upstream pipeline while the access is outstanding, and aborts
// accesses that are misaligned or time out. The writeback value (load data,
// multiplier result or ALU result) is registered for the WB stage.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   ex_mem_*              EX/MEM register contents
//   dm                    data-memory bus (master side)
//   mem_stall             freeze PC, IF/ID, ID/EX, EX/MEM this cycle
//   mem_wb_*              MEM/WB register outputs
//   err_misalign/timeout  sticky error flags, cleared only by reset
//   stall_cnt             saturating count of stalled cycles
//   dbg_state             current FSM state (0 = IDLE, 1 = WAIT)
module mem_wb_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ex_mem_dm2reg,
  input  logic                 ex_mem_we_dm,
  input  logic                 ex_mem_we_reg,
  input  logic [4:0]           ex_mem_rf_wa,
  input  logic [31:0]          ex_mem_alu_out,
  input  logic [31:0]          ex_mem_wd_dm,
  input  logic [31:0]          ex_mem_multi,
  input  logic                 ex_mem_muxmul,
  mem_wb_stage_if.master       dm,
  output logic                 mem_stall,
  output logic                 mem_wb_we_reg,
  output logic [4:0]           mem_wb_rf_wa,
  output logic [31:0]          mem_wb_wd,
  output logic                 err_misalign,
  output logic                 err_timeout,
  output logic [15:0]          stall_cnt,
  output logic                 dbg_state
);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT);

  state_t      r_state;
  logic [7:0]  r_timer;
  logic        r_we_reg;
  logic [4:0]  r_rf_wa;
  logic [31:0] r_wd;
  logic        r_err_misalign;
  logic        r_err_timeout;
  logic [15:0] r_stall_cnt;

  logic        w_mem_op;
  logic        w_misalign;
  logic        w_issue;
  logic        w_req;
  logic        w_timeout;
  logic        w_stall;
  logic [31:0] w_wb_data;

  assign w_mem_op   = ex_mem_dm2reg | ex_mem_we_dm;
  // Only meaningful in IDLE; in WAIT the EX/MEM contents are frozen and
  // were already found aligned when the request was issued.
  assign w_misalign = (r_state == S_IDLE) & w_mem_op & (ex_mem_alu_out[1:0] != 2'b00);
  assign w_issue    = (r_state == S_IDLE) & w_mem_op & ~w_misalign;

  // Gated by rst_n so the request disappears the instant reset is asserted.
  assign w_req      = rst_n & (w_issue | (r_state == S_WAIT));
  // Last WAIT cycle without ack: request is still up this cycle, dropped next.
  assign w_timeout  = (r_state == S_WAIT) & ~dm.dm_ack & (r_timer == TO_LAST);
  assign w_stall    = w_req & ~dm.dm_ack & ~w_timeout;

  // A load wins if both dm2reg and we_dm are set.
  assign dm.dm_req   = w_req;
  assign dm.dm_we    = ex_mem_we_dm & ~ex_mem_dm2reg;
  assign dm.dm_addr  = ex_mem_alu_out;
  assign dm.dm_wdata = ex_mem_wd_dm;

  assign w_wb_data = ex_mem_dm2reg ? dm.dm_rdata
                   : (ex_mem_muxmul ? ex_mem_multi : ex_mem_alu_out);

  // Access FSM: timer counts WAIT cycles, starting at 1 in the first one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_timer <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_issue && !dm.dm_ack) begin
            r_state <= S_WAIT;
            r_timer <= 8'd1;
          end
        end
        S_WAIT: begin
          if (dm.dm_ack || w_timeout) begin
            r_state <= S_IDLE;
            r_timer <= 8'd0;
          end else begin
            r_timer <= r_timer + 8'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_timer <= 8'd0;
        end
      endcase
    end
  end

  // MEM/WB register: bubble while stalled, write dropped on abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we_reg <= 1'b0;
      r_rf_wa  <= 5'd0;
      r_wd     <= 32'd0;
    end else if (w_stall) begin
      r_we_reg <= 1'b0;
      r_rf_wa  <= 5'd0;
      r_wd     <= 32'd0;
    end else begin
      r_we_reg <= ex_mem_we_reg & ~w_misalign & ~w_timeout;
      r_rf_wa  <= ex_mem_rf_wa;
      r_wd     <= w_wb_data;
    end
  end

  // Sticky errors and stall statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_misalign <= 1'b0;
      r_err_timeout  <= 1'b0;
      r_stall_cnt    <= 16'd0;
    end else begin
      if (w_misalign) r_err_misalign <= 1'b1;
      if (w_timeout)  r_err_timeout  <= 1'b1;
      if (w_stall && (r_stall_cnt != 16'hFFFF)) r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign mem_stall     = w_stall;
  assign mem_wb_we_reg = r_we_reg;
  assign mem_wb_rf_wa  = r_rf_wa;
  assign mem_wb_wd     = r_wd;
  assign err_misalign  = r_err_misalign;
  assign err_timeout   = r_err_timeout;
  assign stall_cnt     = r_stall_cnt;
  assign dbg_state     = r_state;

endmodule
